// File: rtl/posit_lut_pkg.sv
// Shared types for the LUT posit adder arbiter: posit word, NaR helpers, issue tag.
// Define POSIT_NAR_BYPASS_EN to carry a NaR flag alongside each issued tag.
package posit_lut_pkg;

  localparam int POSIT_SIZE = 4;
  localparam int NUM_REQ    = 4;
  localparam int ID_W       = $clog2(NUM_REQ);

  typedef logic [POSIT_SIZE-1:0] posit_t;

  localparam posit_t POSIT_NAR = {1'b1, {(POSIT_SIZE-1){1'b0}}};

  function automatic logic is_nar(input posit_t p);
    return (p == POSIT_NAR);
  endfunction

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
`ifdef POSIT_NAR_BYPASS_EN
    logic            nar;
`endif
  } issue_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted req starting at ptr, wrapping.
// Latency 0; no state, the pointer register lives in the parent.
module rr_arbiter #(
  parameter int numReq = 4,
  localparam int idW = $clog2(numReq)
) (
  input  logic [numReq-1:0] req,
  input  logic [idW-1:0]    ptr,
  output logic [numReq-1:0] gnt,
  output logic [idW-1:0]    idx,
  output logic              any
);

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int off = 0; off < numReq; off++) begin
      int c;
      c = int'(ptr) + off;
      if (c >= numReq) c = c - numReq;
      if (!any && req[c]) begin
        any    = 1'b1;
        idx    = idW'(c);
        gnt[c] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/posit_lut_add_arbiter.sv
// Shares one fixed-latency LUT posit adder among numReq clients; results return lutLatency cycles after grant.
// No stall: one issue per cycle, responses have no backpressure. Optional POSIT_NAR_BYPASS_EN forces NaR results.
module posit_lut_add_arbiter
  import posit_lut_pkg::*;
#(
  parameter int positSize  = POSIT_SIZE,
  parameter int numReq     = NUM_REQ,
  parameter int lutLatency = 2,
  localparam int idW = $clog2(numReq)
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic [numReq-1:0]           REQ_VALID,
  input  logic [numReq*positSize-1:0] REQ_A,
  input  logic [numReq*positSize-1:0] REQ_B,
  output logic [numReq-1:0]           REQ_READY,
  output logic [positSize-1:0]        ADD_A1,
  output logic [positSize-1:0]        ADD_A2,
  input  logic [positSize-1:0]        ADD_DATA,
  output logic [numReq-1:0]           RSP_VALID,
  output logic [idW-1:0]              RSP_ID,
  output logic [positSize-1:0]        RSP_DATA
);

  logic [numReq-1:0] req_gated;
  logic [numReq-1:0] gnt;
  logic [idW-1:0]    gnt_idx;
  logic              gnt_any;
  logic [idW-1:0]    ptr;
  issue_tag_t        tag_in;
  issue_tag_t        pipe [lutLatency];
  issue_tag_t        last;

  // Holding grants off during reset keeps REQ_READY and the adder operands quiet.
  assign req_gated = RST_N ? REQ_VALID : '0;

  rr_arbiter #(.numReq(numReq)) u_arb (
    .req (req_gated),
    .ptr (ptr),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  assign REQ_READY = gnt;

  always_comb begin
    ADD_A1 = '0;
    ADD_A2 = '0;
    for (int i = 0; i < numReq; i++) begin
      if (gnt[i]) begin
        ADD_A1 = REQ_A[i*positSize +: positSize];
        ADD_A2 = REQ_B[i*positSize +: positSize];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ptr <= '0;
    end else if (gnt_any) begin
      ptr <= (int'(gnt_idx) == numReq-1) ? '0 : gnt_idx + idW'(1);
    end
  end

  always_comb begin
    tag_in       = '0;
    tag_in.valid = gnt_any;
    tag_in.id    = gnt_idx;
`ifdef POSIT_NAR_BYPASS_EN
    tag_in.nar   = gnt_any & (is_nar(posit_t'(ADD_A1)) | is_nar(posit_t'(ADD_A2)));
`endif
  end

  // Tag pipeline mirrors the adder's registered depth; it never stalls.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int k = 0; k < lutLatency; k++) pipe[k] <= '0;
    end else begin
      pipe[0] <= tag_in;
      for (int k = 1; k < lutLatency; k++) pipe[k] <= pipe[k-1];
    end
  end

  assign last      = pipe[lutLatency-1];
  assign RSP_VALID = last.valid ? (numReq'(1) << last.id) : '0;
  assign RSP_ID    = last.id;

  always_comb begin
    RSP_DATA = RST_N ? ADD_DATA : '0;
`ifdef POSIT_NAR_BYPASS_EN
    if (RST_N && last.nar) RSP_DATA = positSize'(POSIT_NAR);
`endif
  end

endmodule

// File: tb/tb_posit_lut_add_arbiter.sv
// Directed bench for posit_lut_add_arbiter; the shared adder is modelled as a 2-stage (a+b) mod 16 pipeline.
module tb_posit_lut_add_arbiter;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [3:0]  REQ_VALID;
  logic [15:0] REQ_A, REQ_B;
  logic [3:0]  REQ_READY;
  logic [3:0]  ADD_A1, ADD_A2, ADD_DATA;
  logic [3:0]  RSP_VALID;
  logic [1:0]  RSP_ID;
  logic [3:0]  RSP_DATA;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  posit_lut_add_arbiter dut (
    .CLK(CLK), .RST_N(RST_N),
    .REQ_VALID(REQ_VALID), .REQ_A(REQ_A), .REQ_B(REQ_B), .REQ_READY(REQ_READY),
    .ADD_A1(ADD_A1), .ADD_A2(ADD_A2), .ADD_DATA(ADD_DATA),
    .RSP_VALID(RSP_VALID), .RSP_ID(RSP_ID), .RSP_DATA(RSP_DATA)
  );

  logic [3:0] s1, s2;
  always @(posedge CLK) begin
    s1 <= ADD_A1 + ADD_A2;
    s2 <= s1;
  end
  assign ADD_DATA = s2;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    REQ_VALID = '0;
    step();
    RST_N = 1'b1;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    REQ_VALID = 4'hF;
    REQ_A = 16'h4321;
    REQ_B = 16'h3210;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if (REQ_READY !== 4'b0) begin errors++; $display("FAIL reset_ready: got %b want 0000", REQ_READY); end
      checks++; if (RSP_VALID !== 4'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0000", RSP_VALID); end
      checks++; if (ADD_A1 !== 4'h0) begin errors++; $display("FAIL reset_add_a1: got %h want 0", ADD_A1); end
      checks++; if (RSP_ID !== 2'd0) begin errors++; $display("FAIL reset_rsp_id: got %0d want 0", RSP_ID); end
      checks++; if (RSP_DATA !== 4'h0) begin errors++; $display("FAIL reset_rsp_data: got %h want 0", RSP_DATA); end
    end
  endtask

  task automatic test_single();
    do_reset();
    REQ_A = 16'h0030;
    REQ_B = 16'h0020;
    REQ_VALID = 4'b0010;
    #1;
    checks++; if (REQ_READY !== 4'b0010) begin errors++; $display("FAIL single_ready: got %b want 0010", REQ_READY); end
    checks++; if (ADD_A1 !== 4'h3) begin errors++; $display("FAIL single_a1: got %h want 3", ADD_A1); end
    checks++; if (ADD_A2 !== 4'h2) begin errors++; $display("FAIL single_a2: got %h want 2", ADD_A2); end
    step();
    REQ_VALID = 4'b0;
    #1;
    checks++; if (REQ_READY !== 4'b0) begin errors++; $display("FAIL idle_ready: got %b want 0000", REQ_READY); end
    checks++; if (ADD_A1 !== 4'h0) begin errors++; $display("FAIL idle_a1: got %h want 0", ADD_A1); end
    checks++; if (RSP_VALID !== 4'b0) begin errors++; $display("FAIL single_early_rsp: got %b want 0000", RSP_VALID); end
    step();
    checks++; if (RSP_VALID !== 4'b0010) begin errors++; $display("FAIL single_rsp_valid: got %b want 0010", RSP_VALID); end
    checks++; if (RSP_ID !== 2'd1) begin errors++; $display("FAIL single_rsp_id: got %0d want 1", RSP_ID); end
    checks++; if (RSP_DATA !== 4'h5) begin errors++; $display("FAIL single_rsp_data: got %h want 5", RSP_DATA); end
    step();
    checks++; if (RSP_VALID !== 4'b0) begin errors++; $display("FAIL single_strobe_len: got %b want 0000", RSP_VALID); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_gnt [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [3:0] exp_sum [4] = '{4'h1, 4'h3, 4'h5, 4'h7};
    do_reset();
    REQ_A = 16'h4321;
    REQ_B = 16'h3210;
    REQ_VALID = 4'hF;
    for (int k = 0; k < 8; k++) begin
      #1;
      checks++; if (REQ_READY !== exp_gnt[k]) begin errors++; $display("FAIL rr_grant[%0d]: got %b want %b", k, REQ_READY, exp_gnt[k]); end
      if (k >= 2) begin
        checks++; if (RSP_VALID !== exp_gnt[k-2]) begin errors++; $display("FAIL rr_rsp_valid[%0d]: got %b want %b", k, RSP_VALID, exp_gnt[k-2]); end
        checks++; if (RSP_DATA !== exp_sum[(k-2)%4]) begin errors++; $display("FAIL rr_rsp_data[%0d]: got %h want %h", k, RSP_DATA, exp_sum[(k-2)%4]); end
        checks++; if (RSP_ID !== 2'((k-2)%4)) begin errors++; $display("FAIL rr_rsp_id[%0d]: got %0d want %0d", k, RSP_ID, (k-2)%4); end
      end
      step();
    end
    REQ_VALID = '0;
  endtask

  task automatic test_skip();
    do_reset();
    REQ_VALID = 4'b0100;
    #1;
    checks++; if (REQ_READY !== 4'b0100) begin errors++; $display("FAIL skip_g2: got %b want 0100", REQ_READY); end
    step();
    REQ_VALID = 4'b1001;
    #1;
    checks++; if (REQ_READY !== 4'b1000) begin errors++; $display("FAIL skip_g3: got %b want 1000", REQ_READY); end
    step();
    #1;
    checks++; if (REQ_READY !== 4'b0001) begin errors++; $display("FAIL skip_wrap_g0: got %b want 0001", REQ_READY); end
    step();
    REQ_VALID = '0;
  endtask

  task automatic test_reset_inflight();
    do_reset();
    REQ_VALID = 4'b0011;
    step();
    step();
    REQ_VALID = '0;
    RST_N = 1'b0;
    #1;
    checks++; if (RSP_VALID !== 4'b0) begin errors++; $display("FAIL inflight_async_clear: got %b want 0000", RSP_VALID); end
    step();
    RST_N = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (RSP_VALID !== 4'b0) begin errors++; $display("FAIL inflight_ghost[%0d]: got %b want 0000", c, RSP_VALID); end
      step();
    end
    REQ_VALID = 4'b0110;
    #1;
    checks++; if (REQ_READY !== 4'b0010) begin errors++; $display("FAIL inflight_ptr_restart: got %b want 0010", REQ_READY); end
    step();
    REQ_VALID = '0;
    step();
  endtask

`ifdef POSIT_NAR_BYPASS_EN
  task automatic test_nar();
    do_reset();
    REQ_A = 16'h0008;
    REQ_B = 16'h0001;
    REQ_VALID = 4'b0001;
    step();
    REQ_VALID = '0;
    step();
    checks++; if (RSP_VALID !== 4'b0001) begin errors++; $display("FAIL nar_rsp_valid: got %b want 0001", RSP_VALID); end
    checks++; if (RSP_DATA !== 4'h8) begin errors++; $display("FAIL nar_rsp_data: got %h want 8", RSP_DATA); end
    step();
  endtask
`endif

  initial begin
    RST_N = 1'b0;
    REQ_VALID = '0;
    REQ_A = '0;
    REQ_B = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_skip();
    test_reset_inflight();
`ifdef POSIT_NAR_BYPASS_EN
    test_nar();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/posit_lut_add_arbiter.md
# posit_lut_add_arbiter

Round-robin controller that shares one LUT-based posit adder datapath (map LUT → map LUT sum → unmap LUT, fixed registered latency) among `numReq` requesters. Each cycle it grants at most one valid requester, drives that requester's operands onto the adder address ports, and tags the issue slot with the requester index. When the sum emerges `lutLatency` cycles later, it steers the result back to the originating requester. It sits between the posit compute clients and the single shared adder instance.

## Interface
- `positSize`, 4: posit width in bits.
- `numReq`, 4: number of requesters, ≥2.
- `lutLatency`, 2: cycles from adder address presentation to valid `DATA`; it is 1 for the map LUT plus 1 for the unmap LUT.
- `CLK` in 1: clock, rising edge.
- `RST_N` in 1: asynchronous active-low reset.
- `REQ_VALID` in `numReq`: per-requester operand valid.
- `REQ_A` in `numReq*positSize`: operand A; requester i occupies slice `[i*positSize +: positSize]`.
- `REQ_B` in `numReq*positSize`: operand B; uses the same slicing as `REQ_A`.
- `REQ_READY` out `numReq`: one-hot grant; a transfer occurs when `REQ_VALID[i] & REQ_READY[i]`.
- `ADD_A1` out `positSize`: operand 1 to the shared adder.
- `ADD_A2` out `positSize`: operand 2 to the shared adder.
- `ADD_DATA` in `positSize`: sum from the shared adder, valid `lutLatency` cycles after issue.
- `RSP_VALID` out `numReq`: one-hot, single-cycle result strobe.
- `RSP_ID` out `$clog2(numReq)`: index of the requester being answered.
- `RSP_DATA` out `positSize`: result, shared by all requesters.

## Operation
- Arbitration is round-robin over `REQ_VALID`. The search starts at pointer `ptr` and proceeds ptr, ptr+1, …, wrapping mod `numReq`. The first valid requester found wins.
- `REQ_READY` is combinational from `REQ_VALID` and `ptr`. It is all-zero when no requester is valid or while `RST_N`=0.
- On a grant to requester g, `ptr` ← (g+1) mod `numReq` at the next edge. With no grant, `ptr` holds.
- `ADD_A1`/`ADD_A2` present the granted requester's `REQ_A`/`REQ_B` in the same cycle. They are 0 when nothing is granted.
- The issue pipeline has `lutLatency` stages of {valid, id[, nar]}.
  - Stage 0 loads {grant_any, g} each cycle.
  - Stage k loads from stage k-1 each cycle.
  - The pipeline never stalls, because the adder has no enable. Exactly one issue per cycle is possible.
- The last stage drives the outputs:
  - `RSP_VALID` = valid ? (1<<id) : 0.
  - `RSP_ID` = id.
  - `RSP_DATA` = `ADD_DATA`.
- Responses carry no backpressure. Requesters must accept `RSP_VALID` in the cycle it is asserted.
- A requester may hold `REQ_VALID` high continuously. Each grant then consumes one operand pair.

## Timing
- Reset values:
  - `ptr`=0 and all pipeline stages invalid.
  - `RSP_VALID`=0, `RSP_ID`=0, `RSP_DATA`=0.
  - `REQ_READY`=0, `ADD_A1`=0, `ADD_A2`=0.
- Latency: a grant in cycle t produces `RSP_VALID` in cycle t+`lutLatency`.
- Throughput: one result per cycle when any requester is continuously valid.
- Fairness: with all `numReq` requesters continuously valid, each is granted exactly once per `numReq` cycles.
- Simultaneous grant and response for the same requester in one cycle is legal and independent.
- Reset asserted mid-operation clears in-flight tags immediately (asynchronously). No response for pre-reset issues ever appears.
- `ptr` wraps from `numReq`-1 to 0.

## Configuration
- `POSIT_NAR_BYPASS_EN` defined:
  - Each stage carries a `nar` bit, set at issue when either operand equals NaR (MSB 1, all other bits 0).
  - At the output, `nar`=1 forces `RSP_DATA` = NaR regardless of `ADD_DATA`.
- `POSIT_NAR_BYPASS_EN` undefined:
  - No `nar` bit is carried.
  - `RSP_DATA` is always `ADD_DATA`.

## Structure
- Package `posit_lut_pkg` holds:
  - typedef `posit_t` (logic[positSize-1:0]).
  - function `is_nar(posit_t)` and constant `POSIT_NAR`.
  - typedef `issue_tag_t` struct {valid, id, nar}.
- One sub-module, `rr_arbiter`. Parameter `numReq`; inputs req vector and `ptr`; output one-hot grant and index. Purely combinational, with the pointer register kept in the parent.

## Test plan
- Reset with all `REQ_VALID`=1 while `RST_N`=0 → `REQ_READY`=0, `RSP_VALID`=0 and `ADD_A1`=0 throughout reset.
- Requester 1 only, A=0x3, B=0x2 at cycle 0 → `REQ_READY`=4'b0010, `ADD_A1`=0x3 and `ADD_A2`=0x2 at cycle 0. At cycle 2: `RSP_VALID`=4'b0010, `RSP_ID`=1, and `RSP_DATA` equal to the `ADD_DATA` model value.
- All four requesters continuously valid from reset release → grant order 0,1,2,3,0,1,… one per cycle. Responses follow in the same order 2 cycles later.
- Requester 2 granted, then next cycle only requesters 0 and 3 valid → requester 3 granted; requester 0 granted the cycle after.
- With `POSIT_NAR_BYPASS_EN` defined, requester 0 issues A=0x8, B=0x1 → `RSP_DATA`=0x8 at t+2 regardless of `ADD_DATA`.
- Two issues in flight, then `RST_N` pulsed low for one cycle → no `RSP_VALID` in any later cycle until new grants; `ptr` restarts at 0.
